// File: rtl/pattern_stream_ctrl.sv
// pattern_stream_ctrl: word-to-serial sequencer for a '1101' Moore detector.
// Takes a WIDTH-bit word on in_valid/in_ready, clears the detector,
// shifts the word out LSB-first on det_i, records det_o per bit
// position into out_mask/out_count, and offers it on out_valid/out_ready.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  word handshake, in_data streamed bit 0 first
//   det_clr, det_i  detector clear and serial bit
//   det_o           registered detector output (one-cycle lag)
//   busy            high whenever not IDLE
//   out_valid/ready result handshake, out_mask/out_count result
module pattern_stream_ctrl #(
   parameter int WIDTH        = 10,
   parameter int CLEAR_CYCLES = 2,
   parameter int CNT_W        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             det_clr,
   output logic             det_i,
   input  logic             det_o,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mask,
   output logic [CNT_W-1:0] out_count
);

   localparam int CMAX = (WIDTH > CLEAR_CYCLES) ? WIDTH : CLEAR_CYCLES;
   localparam int TW   = $clog2(CMAX + 1);

   localparam logic [TW-1:0] CLR_LAST = TW'(CLEAR_CYCLES - 1);
   localparam logic [TW-1:0] BIT_LAST = TW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] mask_q;
   logic [CNT_W-1:0] count_q;
   logic [TW-1:0]    tick_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b1;
      det_clr   = 1'b0;
      det_i     = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy     = 1'b0;
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            det_clr = 1'b1;
            if (tick_q == CLR_LAST) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            det_i = shreg_q[0];
            if (tick_q == BIT_LAST) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // det_o lags det_i by one cycle, so the sample taken at the end of
   // stream cycle k belongs to bit k-1. Shifting it in from the top
   // lands bit 0's sample at mask[0] after exactly WIDTH shifts
   // (stream cycles 1..WIDTH-1 plus the drain cycle).
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         mask_q  <= '0;
         count_q <= '0;
         tick_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               tick_q <= '0;
               if (in_valid) begin
                  shreg_q <= in_data;
                  mask_q  <= '0;
                  count_q <= '0;
               end
            end
            CLEAR: begin
               if (tick_q == CLR_LAST) begin
                  tick_q <= '0;
               end else begin
                  tick_q <= tick_q + TW'(1);
               end
            end
            STREAM: begin
               tick_q  <= tick_q + TW'(1);
               shreg_q <= shreg_q >> 1;
               if (tick_q != '0) begin
                  mask_q  <= {det_o, mask_q[WIDTH-1:1]};
                  count_q <= count_q + CNT_W'(det_o);
               end
            end
            DRAIN: begin
               tick_q  <= '0;
               mask_q  <= {det_o, mask_q[WIDTH-1:1]};
               count_q <= count_q + CNT_W'(det_o);
            end
            DONE: begin
               tick_q <= '0;
            end
            default: begin
               tick_q <= '0;
            end
         endcase
      end
   end

   assign out_mask  = mask_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// tb_pattern_stream_ctrl: directed bench pairing the controller with a
// behavioural overlapping '1101' Moore detector with synchronous clear.
module tb_pattern_stream_ctrl;

   localparam int W = 10;

   logic         tb_clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         det_clr;
   logic         det_i;
   logic         det_o;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_mask;
   logic [3:0]   out_count;

   logic         inj = 1'b0;
   logic [2:0]   ms = 3'd0;
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 tb_clk = ~tb_clk;

   always @(posedge tb_clk) cyc <= cyc + 1;

   // Reference detector: 0:-, 1:"1", 2:"11", 3:"110", 4:"1101" (fires)
   always @(posedge tb_clk) begin
      if (rst || det_clr) begin
         ms <= 3'd0;
      end else begin
         case (ms)
            3'd0:    ms <= det_i ? 3'd1 : 3'd0;
            3'd1:    ms <= det_i ? 3'd2 : 3'd0;
            3'd2:    ms <= det_i ? 3'd2 : 3'd3;
            3'd3:    ms <= det_i ? 3'd4 : 3'd0;
            default: ms <= det_i ? 3'd2 : 3'd0;
         endcase
      end
   end

   assign det_o = (ms == 3'd4) | inj;

   pattern_stream_ctrl #(
      .WIDTH(W),
      .CLEAR_CYCLES(2)
   ) dut (
      .clk      (tb_clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .det_clr  (det_clr),
      .det_i    (det_i),
      .det_o    (det_o),
      .busy     (busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_mask (out_mask),
      .out_count(out_count)
   );

   typedef struct {
      logic [W-1:0] d;
      logic [W-1:0] m;
      int           c;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge after the accept edge.
   task automatic send(input logic [W-1:0] d, output int acc);
      int k;
      in_data  = d;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge tb_clk);
         k++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      acc = cyc + 1;
      @(negedge tb_clk);
      in_valid = 1'b0;
   endtask

   // Offsets are cycle numbers after the accept edge (first cycle = 1).
   task automatic wait_done(input int acc, output int lat,
                            output int clr_bits, output int di_bad);
      int k;
      int off;
      clr_bits = 0;
      di_bad   = 0;
      k = 0;
      while (!out_valid && k < 60) begin
         off = cyc - acc + 1;
         if (det_clr && off < 31) clr_bits |= (1 << off);
         if (det_i && !(off >= 3 && off <= 12)) di_bad = 1;
         @(negedge tb_clk);
         k++;
      end
      if (!out_valid) check("done_timeout", 0, 1);
      lat = cyc - acc + 1;
   endtask

   task automatic take(output logic [W-1:0] m, output int c);
      m = out_mask;
      c = int'(out_count);
      out_ready = 1'b1;
      @(negedge tb_clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int acc, acc1, acc2, hs1, lat, cb, db, c, c1, c2, na, nh;
      logic [W-1:0] m, m1, m2;

      vecs[0] = '{10'h000, 10'h000, 0};
      vecs[1] = '{10'h3FF, 10'h000, 0};
      vecs[2] = '{10'h2DB, 10'h248, 3};
      vecs[3] = '{10'h00B, 10'h008, 1};
      vecs[4] = '{10'h03A, 10'h000, 0};
      vecs[5] = '{10'h36D, 10'h120, 2};
      vecs[6] = '{10'h2C0, 10'h200, 1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge tb_clk);
      check("rst_busy", int'(busy), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_det_clr", int'(det_clr), 0);
      check("rst_det_i", int'(det_i), 0);
      check("rst_mask", int'(out_mask), 0);
      check("rst_count", int'(out_count), 0);
      rst = 1'b0;
      @(negedge tb_clk);
      check("rst_in_ready", int'(in_ready), 1);

      for (int i = 0; i < 7; i++) begin
         send(vecs[i].d, acc);
         wait_done(acc, lat, cb, db);
         take(m, c);
         check($sformatf("v%0d_mask", i), int'(m), int'(vecs[i].m));
         check($sformatf("v%0d_count", i), c, vecs[i].c);
         check($sformatf("v%0d_latency", i), lat, 14);
         check($sformatf("v%0d_clr_cycles", i), cb, 6);
         check($sformatf("v%0d_det_i_idle", i), db, 0);
         check($sformatf("v%0d_ready_after", i), int'(in_ready), 1);
      end

      // det_o forced high: every position recorded, count reaches WIDTH
      inj = 1'b1;
      send(10'h000, acc);
      wait_done(acc, lat, cb, db);
      take(m, c);
      inj = 1'b0;
      check("inj_mask", int'(m), 'h3FF);
      check("inj_count", c, 10);
      check("inj_latency", lat, 14);

      // Backpressure with a competing word held on the input
      send(10'h2DB, acc);
      wait_done(acc, lat, cb, db);
      in_data  = 10'h00B;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_mask", int'(out_mask), 'h248);
         check("bp_count", int'(out_count), 3);
         check("bp_in_ready", int'(in_ready), 0);
         @(negedge tb_clk);
      end
      out_ready = 1'b1;
      check("bp_ready_at_hs", int'(in_ready), 0);
      @(negedge tb_clk);
      out_ready = 1'b0;
      check("bp_ready_post_hs", int'(in_ready), 1);
      check("bp_valid_post_hs", int'(out_valid), 0);
      acc = cyc + 1;
      @(negedge tb_clk);
      in_valid = 1'b0;
      check("bp_busy_after_acc", int'(busy), 1);
      check("bp_ready_after_acc", int'(in_ready), 0);
      wait_done(acc, lat, cb, db);
      take(m, c);
      check("bp2_mask", int'(m), 'h008);
      check("bp2_count", c, 1);
      check("bp2_latency", lat, 14);

      // Back-to-back with in_valid and out_ready held high
      in_data   = 10'h2DB;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      na = 0; nh = 0; acc1 = 0; acc2 = 0; hs1 = 0;
      m1 = '0; m2 = '0; c1 = 0; c2 = 0;
      for (int k = 0; k < 80 && nh < 2; k++) begin
         if (in_valid && in_ready) begin
            if (na == 0) acc1 = cyc + 1;
            else acc2 = cyc + 1;
            na++;
         end
         if (out_valid) begin
            if (nh == 0) begin
               hs1 = cyc + 1;
               m1  = out_mask;
               c1  = int'(out_count);
            end else begin
               m2 = out_mask;
               c2 = int'(out_count);
            end
            nh++;
         end
         @(negedge tb_clk);
         if (na == 1) in_data = 10'h36D;
         if (na >= 2) in_valid = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_handshakes", nh, 2);
      check("b2b_first_latency", hs1 - acc1, 14);
      check("b2b_gap", acc2 - hs1, 1);
      check("b2b_mask1", int'(m1), 'h248);
      check("b2b_count1", c1, 3);
      check("b2b_mask2", int'(m2), 'h120);
      check("b2b_count2", c2, 2);

      // Reset in the middle of streaming
      @(negedge tb_clk);
      send(10'h2DB, acc);
      repeat (6) @(negedge tb_clk);
      check("mid_busy", int'(busy), 1);
      rst = 1'b1;
      repeat (2) @(negedge tb_clk);
      rst = 1'b0;
      check("mr_in_ready", int'(in_ready), 1);
      check("mr_busy", int'(busy), 0);
      check("mr_out_valid", int'(out_valid), 0);
      check("mr_det_clr", int'(det_clr), 0);
      check("mr_det_i", int'(det_i), 0);
      check("mr_mask", int'(out_mask), 0);
      check("mr_count", int'(out_count), 0);
      send(10'h00B, acc);
      wait_done(acc, lat, cb, db);
      take(m, c);
      check("mr_next_mask", int'(m), 'h008);
      check("mr_next_count", c, 1);
      check("mr_next_latency", lat, 14);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
